// File: rtl/capture_ram_ctrl.sv
// capture_ram_ctrl
// Controller for a circular pre-/post-trigger capture buffer. It sits in front
// of a 2^AW x (DW+1) block RAM that has a synchronous write and a one-clock
// registered read. The extra RAM bit holds the sample tag.
//
// Ports
//   clock_i, reset_n_i  : clock; asynchronous active-low reset
//   arm_i               : start a new capture (accepted in IDLE or DONE)
//   abort_i             : return to IDLE from any state (highest priority)
//   post_count_i        : samples to store after the trigger sample
//   in_valid_i/in_data_i/in_tag_i/trigger_i : incoming sample stream
//   read_start_i        : begin oldest-first readback (accepted in DONE)
//   out_valid_o/out_ready_i/out_data_o/out_tag_o : readback stream
//   ram_*_o             : registered RAM control; ram_do_i/ram_dop_i is read data
//   armed_o/triggered_o/done_o/sample_count_o : status
module capture_ram_ctrl #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          arm_i,
    input  logic          abort_i,
    input  logic [AW-1:0] post_count_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_tag_i,
    input  logic          trigger_i,
    input  logic          read_start_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_tag_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_di_o,
    output logic          ram_dip_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic          ram_ssr_o,
    input  logic [DW-1:0] ram_do_i,
    input  logic          ram_dop_i,
    output logic          armed_o,
    output logic          triggered_o,
    output logic          done_o,
    output logic [AW:0]   sample_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_POST,
        S_DONE,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_OUT
    } state_t;

    localparam logic [AW-1:0] A_ONE = AW'(1);
    localparam logic [AW:0]   C_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   DEPTH = {1'b1, {AW{1'b0}}};

    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic            wrapped_q;
    logic [AW-1:0]   post_cnt_q;
    logic [AW:0]     remaining_q;
    logic [AW-1:0]   ram_addr_q;
    logic [DW-1:0]   ram_di_q;
    logic            ram_dip_q;
    logic            ram_en_q;
    logic            ram_we_q;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic            out_tag_q;

    // Once the buffer has wrapped, the write pointer points at the oldest sample.
    logic [AW:0]     sample_count_d;
    logic [AW-1:0]   rd_start_d;

    assign sample_count_d = wrapped_q ? DEPTH : {1'b0, wr_ptr_q};
    assign rd_start_d     = wrapped_q ? wr_ptr_q : '0;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            wrapped_q   <= 1'b0;
            post_cnt_q  <= '0;
            remaining_q <= '0;
            ram_addr_q  <= '0;
            ram_di_q    <= '0;
            ram_dip_q   <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= 1'b0;
        end else begin
            // RAM enables are single-cycle pulses unless a state below issues an access.
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            if (abort_i) begin
                state_q     <= S_IDLE;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (arm_i) begin
                            wr_ptr_q   <= '0;
                            wrapped_q  <= 1'b0;
                            post_cnt_q <= post_count_i;
                            state_q    <= S_FILL;
                        end else if (state_q == S_DONE && read_start_i) begin
                            ram_addr_q  <= rd_start_d;
                            ram_en_q    <= 1'b1;
                            remaining_q <= sample_count_d;
                            state_q     <= S_RD_ADDR;
                        end
                    end
                    S_FILL, S_POST: begin
                        if (in_valid_i) begin
                            ram_addr_q <= wr_ptr_q;
                            ram_di_q   <= in_data_i;
                            ram_dip_q  <= in_tag_i;
                            ram_en_q   <= 1'b1;
                            ram_we_q   <= 1'b1;
                            wr_ptr_q   <= wr_ptr_q + A_ONE;
                            if (wr_ptr_q == '1) begin
                                wrapped_q <= 1'b1;
                            end
                            if (state_q == S_FILL) begin
                                if (trigger_i) begin
                                    state_q <= (post_cnt_q == '0) ? S_DONE : S_POST;
                                end
                            end else begin
                                post_cnt_q <= post_cnt_q - A_ONE;
                                if (post_cnt_q == A_ONE) begin
                                    state_q <= S_DONE;
                                end
                            end
                        end
                    end
                    S_RD_ADDR: begin
                        state_q <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        out_data_q  <= ram_do_i;
                        out_tag_q   <= ram_dop_i;
                        out_valid_q <= 1'b1;
                        state_q     <= S_RD_OUT;
                    end
                    S_RD_OUT: begin
                        if (out_ready_i) begin
                            out_valid_q <= 1'b0;
                            remaining_q <= remaining_q - C_ONE;
                            if (remaining_q == C_ONE) begin
                                state_q <= S_DONE;
                            end else begin
                                ram_addr_q <= ram_addr_q + A_ONE;
                                ram_en_q   <= 1'b1;
                                state_q    <= S_RD_ADDR;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_data_q;
    assign out_tag_o      = out_tag_q;
    assign ram_addr_o     = ram_addr_q;
    assign ram_di_o       = ram_di_q;
    assign ram_dip_o      = ram_dip_q;
    assign ram_en_o       = ram_en_q;
    assign ram_we_o       = ram_we_q;
    assign ram_ssr_o      = 1'b0;
    assign armed_o        = (state_q == S_FILL) || (state_q == S_POST);
    assign triggered_o    = (state_q == S_POST);
    assign done_o         = (state_q == S_DONE);
    assign sample_count_o = sample_count_d;

endmodule

// File: tb/tb_capture_ram_ctrl.sv
// Testbench for capture_ram_ctrl with a behavioural 2048x9 block RAM.
module tb_capture_ram_ctrl;
    localparam int AW = 11;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          arm, abort, in_valid, in_tag, trigger, read_start, out_ready;
    logic [AW-1:0] post_count;
    logic [DW-1:0] in_data;
    logic          out_valid, out_tag;
    logic [DW-1:0] out_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di, ram_do;
    logic          ram_dip, ram_en, ram_we, ram_ssr, ram_dop;
    logic          armed, triggered, done;
    logic [AW:0]   sample_count;

    capture_ram_ctrl #(.AW(AW), .DW(DW)) dut (
        .clock_i(clk), .reset_n_i(reset_n), .arm_i(arm), .abort_i(abort),
        .post_count_i(post_count), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_tag_i(in_tag), .trigger_i(trigger), .read_start_i(read_start),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_tag_o(out_tag), .ram_addr_o(ram_addr), .ram_di_o(ram_di),
        .ram_dip_o(ram_dip), .ram_en_o(ram_en), .ram_we_o(ram_we),
        .ram_ssr_o(ram_ssr), .ram_do_i(ram_do), .ram_dop_i(ram_dop),
        .armed_o(armed), .triggered_o(triggered), .done_o(done),
        .sample_count_o(sample_count)
    );

    // Behavioural RAM: synchronous write, registered read.
    logic [DW:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= {ram_dip, ram_di};
            else {ram_dop, ram_do} <= mem[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          arm, abort, iv;
        logic [7:0]    d;
        logic          tag, trg, rs, rdy;
        logic [10:0]   pc;
        logic          e_armed, e_trig, e_done;
        logic [11:0]   e_cnt;
        logic          e_en, e_we;
        logic [10:0]   e_addr;
        logic          e_ov;
        logic [7:0]    e_od;
        logic          e_ot;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic a, input logic ab, input logic iv, input logic [7:0] d,
        input logic tg, input logic trg, input logic rs, input logic rdy,
        input logic [10:0] pc, input logic ea, input logic et, input logic ed,
        input logic [11:0] ec, input logic een, input logic ewe,
        input logic [10:0] eaddr, input logic eov, input logic [7:0] eod,
        input logic eot);
        vec_t v;
        v.arm = a; v.abort = ab; v.iv = iv; v.d = d; v.tag = tg; v.trg = trg;
        v.rs = rs; v.rdy = rdy; v.pc = pc; v.e_armed = ea; v.e_trig = et;
        v.e_done = ed; v.e_cnt = ec; v.e_en = een; v.e_we = ewe;
        v.e_addr = eaddr; v.e_ov = eov; v.e_od = eod; v.e_ot = eot;
        return v;
    endfunction

    task automatic idle_inputs();
        arm = 0; abort = 0; in_valid = 0; in_data = 0; in_tag = 0;
        trigger = 0; read_start = 0; out_ready = 0; post_count = 0;
    endtask

    // Oldest-first readback; expected data is (base+k) mod 256, tag is its parity.
    task automatic readback(input int base, input int n, input string nm);
        int got = 0;
        int cyc = 0;
        int last = 0;
        logic [7:0] exp_d;
        read_start = 1; out_ready = 1;
        tick();
        read_start = 0;
        while (!done && cyc < n * 3 + 20) begin
            if (out_valid) begin
                exp_d = 8'(base + got);
                chk($sformatf("%s_data%0d", nm, got), out_data, exp_d);
                chk($sformatf("%s_tag%0d", nm, got), out_tag, ^exp_d);
                if (got == 1) chk($sformatf("%s_gap", nm), cyc - last, 3);
                last = cyc;
                got++;
            end
            tick();
            cyc++;
        end
        out_ready = 0;
        chk($sformatf("%s_beats", nm), got, n);
        chk($sformatf("%s_done", nm), done, 1'b1);
        $display("readback %s beats=%0d cycles=%0d", nm, got, cyc);
    endtask

    initial begin
        int n;
        logic [7:0] kd;
        idle_inputs();
        reset_n = 0;

        // Zero-post capture with a held readback beat.
        vecs.push_back(mk(1,0,0,8'h00,0,0,0,0,11'd0, 1,0,0,12'd0,0,0,11'd0,0,8'h00,0));
        vecs.push_back(mk(0,0,1,8'hA5,1,1,0,0,11'd0, 0,0,1,12'd1,1,1,11'd0,0,8'h00,0));
        vecs.push_back(mk(0,0,1,8'h11,0,0,0,0,11'd0, 0,0,1,12'd1,0,0,11'd0,0,8'h00,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,1,0,11'd0, 0,0,0,12'd1,1,0,11'd0,0,8'h00,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0,0,11'd0, 0,0,0,12'd1,0,0,11'd0,0,8'h00,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0,0,11'd0, 0,0,0,12'd1,0,0,11'd0,1,8'hA5,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0,0,11'd0, 0,0,0,12'd1,0,0,11'd0,1,8'hA5,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0,1,11'd0, 0,0,1,12'd1,0,0,11'd0,0,8'h00,0));
        // Basic capture: post_count=3, trigger on sample 5.
        vecs.push_back(mk(1,0,0,8'h00,0,0,0,0,11'd3, 1,0,0,12'd0,0,0,11'd0,0,8'h00,0));
        for (int k = 0; k < 5; k++) begin
            kd = 8'(k);
            vecs.push_back(mk(0,0,1,kd,^kd,0,0,0,11'd0, 1,0,0,12'(k+1),1,1,11'(k),0,8'h00,0));
        end
        kd = 8'd5;
        vecs.push_back(mk(0,0,1,kd,^kd,1,0,0,11'd0, 1,1,0,12'd6,1,1,11'd5,0,8'h00,0));
        kd = 8'd6;
        vecs.push_back(mk(0,0,1,kd,^kd,1,0,0,11'd0, 1,1,0,12'd7,1,1,11'd6,0,8'h00,0));
        kd = 8'd7;
        vecs.push_back(mk(0,0,1,kd,^kd,0,0,0,11'd0, 1,1,0,12'd8,1,1,11'd7,0,8'h00,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0,0,11'd0, 1,1,0,12'd8,0,0,11'd7,0,8'h00,0));
        kd = 8'd8;
        vecs.push_back(mk(0,0,1,kd,^kd,0,0,0,11'd0, 0,0,1,12'd9,1,1,11'd8,0,8'h00,0));
        kd = 8'd9;
        vecs.push_back(mk(0,0,1,kd,^kd,0,0,0,11'd0, 0,0,1,12'd9,0,0,11'd8,0,8'h00,0));

        // Reset state (asynchronous, checked before any clock edge matters).
        #2;
        chk("rst_armed", armed, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_trig", triggered, 1'b0);
        chk("rst_cnt", sample_count, 0);
        chk("rst_en", ram_en, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_od", out_data, 0);
        chk("rst_ssr", ram_ssr, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1;
        tick();

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            arm = v.arm; abort = v.abort; in_valid = v.iv; in_data = v.d;
            in_tag = v.tag; trigger = v.trg; read_start = v.rs; out_ready = v.rdy;
            post_count = v.pc;
            tick();
            chk($sformatf("v%0d_armed", i), armed, v.e_armed);
            chk($sformatf("v%0d_trig", i), triggered, v.e_trig);
            chk($sformatf("v%0d_done", i), done, v.e_done);
            chk($sformatf("v%0d_cnt", i), sample_count, v.e_cnt);
            chk($sformatf("v%0d_en", i), ram_en, v.e_en);
            chk($sformatf("v%0d_we", i), ram_we, v.e_we);
            chk($sformatf("v%0d_addr", i), ram_addr, v.e_addr);
            chk($sformatf("v%0d_ov", i), out_valid, v.e_ov);
            if (v.e_ov) begin
                chk($sformatf("v%0d_od", i), out_data, v.e_od);
                chk($sformatf("v%0d_ot", i), out_tag, v.e_ot);
            end
            if (v.e_we) begin
                chk($sformatf("v%0d_di", i), ram_di, v.d);
                chk($sformatf("v%0d_dip", i), ram_dip, v.tag);
            end
            $display("vec %0d armed=%0b trig=%0b done=%0b cnt=%0d en=%0b we=%0b addr=%0d ov=%0b",
                     i, armed, triggered, done, sample_count, ram_en, ram_we, ram_addr, out_valid);
        end
        idle_inputs();

        readback(0, 9, "basic");

        // Backpressure on the basic buffer (first sample is 0x00 at address 0).
        read_start = 1; out_ready = 0;
        tick();
        read_start = 0;
        n = 0;
        while (!out_valid && n < 10) begin tick(); n++; end
        chk("bp_reach_out", out_valid, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp_ov%0d", c), out_valid, 1'b1);
            chk($sformatf("bp_od%0d", c), out_data, 8'h00);
            chk($sformatf("bp_en%0d", c), ram_en, 1'b0);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("bp_rel_en", ram_en, 1'b1);
        chk("bp_rel_addr", ram_addr, 1);
        chk("bp_rel_ov", out_valid, 1'b0);
        abort = 1;
        tick();
        abort = 0;
        chk("bp_abort_done", done, 1'b0);
        chk("bp_abort_en", ram_en, 1'b0);
        $display("backpressure held 5 cycles then aborted");

        // Wrap: post_count=100, trigger at i=2500, done after i=2600.
        arm = 1; post_count = 11'd100;
        tick();
        arm = 0; post_count = 0;
        for (int i = 0; i < 3000; i++) begin
            in_valid = 1; in_data = 8'(i); in_tag = ^in_data; trigger = (i == 2500);
            tick();
            if (i == 2599) chk("wrap_not_done", done, 1'b0);
            if (i == 2600) begin
                chk("wrap_done", done, 1'b1);
                chk("wrap_cnt", sample_count, 2048);
            end
        end
        idle_inputs();
        $display("wrap capture cnt=%0d", sample_count);
        readback(553, 2048, "wrap");

        // Abort in POST, ignored writes afterwards, re-arm writes from address 0.
        arm = 1; post_count = 11'd5;
        tick();
        arm = 0; post_count = 0;
        in_valid = 1; in_data = 8'h77; trigger = 1;
        tick();
        trigger = 0;
        chk("ab_post", triggered, 1'b1);
        in_data = 8'h78;
        tick();
        abort = 1; in_data = 8'h99;
        tick();
        abort = 0;
        chk("ab_idle_armed", armed, 1'b0);
        chk("ab_idle_trig", triggered, 1'b0);
        chk("ab_we", ram_we, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("ab_ign_we%0d", c), ram_we, 1'b0);
        end
        in_valid = 0;
        arm = 1; post_count = 0;
        tick();
        arm = 0;
        in_valid = 1; in_data = 8'h3C; in_tag = 0; trigger = 1;
        tick();
        idle_inputs();
        chk("rearm_we", ram_we, 1'b1);
        chk("rearm_addr", ram_addr, 0);
        chk("rearm_done", done, 1'b1);
        chk("rearm_cnt", sample_count, 1);
        $display("abort and re-arm sequence complete");

        // Reset during RD_OUT.
        tick();
        read_start = 1; out_ready = 0;
        tick();
        read_start = 0;
        n = 0;
        while (!out_valid && n < 10) begin tick(); n++; end
        chk("rr_reach_out", out_valid, 1'b1);
        chk("rr_od", out_data, 8'h3C);
        #2 reset_n = 0;
        #1;
        chk("rr_ov", out_valid, 1'b0);
        chk("rr_en", ram_en, 1'b0);
        chk("rr_done", done, 1'b0);
        chk("rr_od_clr", out_data, 0);
        @(negedge clk) reset_n = 1;
        tick();
        chk("rr_idle_armed", armed, 1'b0);
        chk("rr_idle_done", done, 1'b0);
        chk("rr_idle_cnt", sample_count, 0);
        $display("reset during readback complete");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/capture_ram_ctrl.md
Name: capture_ram_ctrl

Overview:
- Capture-buffer controller that sits directly upstream of the 2048x9 sample block RAM (RAMB16_S9-style: synchronous write, one-clock registered read).
- Writes incoming 8-bit samples plus a tag bit into the RAM as a circular pre-/post-trigger buffer.
- Stops after a programmable post-trigger count, then streams the stored samples back oldest-first over a valid/ready port.

Parameters:
AW, 11, RAM address width (depth = 2^AW = 2048)
DW, 8, sample data width (RAM DI width; tag rides on DIP)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
arm  input  1  pulse: start new capture (honoured in IDLE or DONE only)
abort  input  1  pulse: return to IDLE from any state (priority over all other inputs)
post_count  input  AW  post-trigger samples after trigger sample; sampled when arm is accepted
in_valid  input  1  sample strobe
in_data  input  DW  sample data
in_tag  input  1  sample tag bit
trigger  input  1  trigger qualifier; honoured only with in_valid in FILL
read_start  input  1  pulse: begin readback (honoured in DONE only)
out_valid  output  1  readback sample valid
out_ready  input  1  consumer accepts sample
out_data  output  DW  readback data
out_tag  output  1  readback tag
ram_addr  output  AW  RAM ADDR
ram_di  output  DW  RAM DI
ram_dip  output  1  RAM DIP
ram_en  output  1  RAM EN
ram_we  output  1  RAM WE
ram_ssr  output  1  RAM SSR, constant 0
armed  output  1  state is FILL or POST
triggered  output  1  state is POST
done  output  1  state is DONE
sample_count  output  AW+1  valid samples in buffer (0..2048)

Behaviour:
- Reset (async, reset_n=0): state IDLE; wr_ptr=0; wrapped=0; post counter=0; all ram_* outputs=0; out_valid=0; out_data=0; out_tag=0; status outputs=0.
- States: IDLE, FILL, POST, DONE, RD_ADDR, RD_WAIT, RD_OUT.
- All ram_* outputs are registered. RAM samples them on the edge after they are set; ram_do is valid after that edge.
- abort=1: next state IDLE from any state; ram_en/ram_we/out_valid cleared; buffer contents untouched.
- IDLE/DONE + arm: wr_ptr=0, wrapped=0, post counter=post_count, next state FILL.
- arm is ignored in FILL, POST and RD_*.
- FILL + in_valid: ram_addr=wr_ptr, ram_di=in_data, ram_dip=in_tag, ram_en=ram_we=1.
  - wr_ptr increments mod 2048; wrapped is set when wr_ptr goes 2047->0.
  - If trigger=1 on the same cycle: the sample is the trigger sample and is written. Next state is POST, or DONE if post counter=0.
- POST + in_valid: write as above; post counter decrements; when it was 1, next state DONE. trigger is ignored in POST.
- Cycles without in_valid in FILL/POST: ram_en=ram_we=0, no state change.
- in_valid is ignored in IDLE, DONE and RD_*.
- sample_count = wrapped ? 2048 : wr_ptr.
- Read start address = wrapped ? wr_ptr : 0 (oldest sample first).
- DONE + read_start: ram_addr=start, ram_en=1, ram_we=0, remaining=sample_count, next state RD_ADDR.
- RD_ADDR -> RD_WAIT: ram_en=0.
- RD_WAIT -> RD_OUT: out_data/out_tag loaded from ram_do/ram_dop, out_valid=1.
- RD_OUT, out_valid & out_ready: out_valid=0, remaining decrements.
  - If this was the last sample: next state DONE.
  - Otherwise ram_addr increments mod 2048, ram_en=1, next state RD_ADDR.
- Throughput: one sample per 3 clocks at out_ready=1. With out_ready=0, out_valid/out_data/out_tag are held stable.
- Readback is non-destructive and may be repeated from DONE.
- Minimum buffer occupancy in DONE is 1 (the trigger sample).
- Write-to-read hazard: a write issued on the edge entering DONE completes one edge later; the earliest read issue is also one edge later, so the hazard is safe.

Test Plan:
- Basic capture: arm with post_count=3; feed 10 samples in_data=0..9, trigger with sample 5 -> done after sample 8 written, sample_count=9; readback yields 0..8 in order, then state DONE.
- Wrap: post_count=100; feed 3000 samples in_data=i[7:0], trigger at i=2500 -> done after i=2600; sample_count=2048; first readback = 553&8'hFF (0x29), last = 2600&8'hFF (0x28); exactly 2048 out beats.
- Zero post: post_count=0; trigger on first sample in_data=0xA5, in_tag=1 -> done one cycle later, sample_count=1; readback one beat 0xA5 with tag 1.
- Backpressure: hold out_ready=0 for 5 cycles in RD_OUT -> out_valid=1 and out_data unchanged all 5 cycles; no ram_en pulses; release -> next address issued.
- Abort/ignore: abort in POST -> IDLE, ram_we=0; subsequent in_valid writes nothing; re-arm writes from address 0.
- Reset mid-read: drop reset_n during RD_OUT -> out_valid, ram_en, done = 0 immediately without a clock edge; state IDLE after release.
